// File: rtl/aes_key_expansion.sv
// AES-128 key schedule writer: expands the cipher key into 44 columns and stores one byte
// per `word` entry at row*ROW_STRIDE + col, using 1-cycle-latency BRAM ports.
module aes_key_expansion #(
   parameter int unsigned ROW_STRIDE = 120,
   parameter int unsigned NUM_COLS   = 44
) (
   input  logic        ap_clk,
   input  logic        ap_rst,
   input  logic        ap_start,
   output logic        ap_done,
   output logic        ap_idle,
   output logic        ap_ready,
   output logic [4:0]  key_address0,
   output logic        key_ce0,
   input  logic [31:0] key_q0,
   output logic [7:0]  sbox_address0,
   output logic        sbox_ce0,
   input  logic [31:0] sbox_q0,
   output logic [8:0]  word_address0,
   output logic        word_ce0,
   output logic        word_we0,
   output logic [31:0] word_d0,
   output logic [8:0]  word_address1,
   output logic        word_ce1,
   input  logic [31:0] word_q1
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_KRD  = 3'd1;
   localparam logic [2:0] S_KWR  = 3'd2;
   localparam logic [2:0] S_PREV = 3'd3;
   localparam logic [2:0] S_SUB  = 3'd4;
   localparam logic [2:0] S_XOR  = 3'd5;
   localparam logic [2:0] S_DONE = 3'd6;

   localparam logic [5:0] LAST_COL = 6'(NUM_COLS - 1);

   logic [2:0] state_q, state_d;
   logic [5:0] col_q;
   logic [1:0] i_q;
   logic       ph_q;
   logic [7:0] rcon_q;
   logic [7:0] t_q [4];
   logic [7:0] s_q [4];

   logic [1:0] i_nxt;
   logic [8:0] row_base;
   logic [8:0] col_ext;
   logic       unused_q_bits;

   assign i_nxt    = i_q + 2'd1;
   assign row_base = 9'(32'(i_q) * ROW_STRIDE);
   assign col_ext  = {3'd0, col_q};
   assign unused_q_bits = ^{key_q0[31:8], sbox_q0[31:8], word_q1[31:8]};

   // ph_q: 0 = issue the read, 1 = consume its data one cycle later
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (ap_start) state_d = S_KRD;
         S_KRD:   state_d = S_KWR;
         S_KWR:   state_d = (i_q == 2'd3 && col_q == 6'd3) ? S_PREV : S_KRD;
         S_PREV:  if (ph_q && i_q == 2'd3) state_d = (col_q[1:0] == 2'd0) ? S_SUB : S_XOR;
         S_SUB:   if (ph_q && i_q == 2'd3) state_d = S_XOR;
         S_XOR:   if (ph_q && i_q == 2'd3) state_d = (col_q == LAST_COL) ? S_DONE : S_PREV;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q <= S_IDLE;
         col_q   <= 6'd0;
         i_q     <= 2'd0;
         ph_q    <= 1'b0;
         rcon_q  <= 8'h01;
         for (int k = 0; k < 4; k++) begin
            t_q[k] <= 8'd0;
            s_q[k] <= 8'd0;
         end
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (ap_start) begin
                  col_q  <= 6'd0;
                  i_q    <= 2'd0;
                  ph_q   <= 1'b0;
                  rcon_q <= 8'h01;
               end
            end
            S_KWR: begin
               i_q <= i_nxt;
               if (i_q == 2'd3) col_q <= col_q + 6'd1;
            end
            S_PREV, S_SUB, S_XOR: begin
               ph_q <= ~ph_q;
               if (ph_q) begin
                  i_q <= i_nxt;
                  if (state_q == S_PREV) t_q[i_q] <= word_q1[7:0];
                  if (state_q == S_SUB) s_q[i_q] <= sbox_q0[7:0];
                  // t stays stable while it addresses the S-box, then takes RotWord/SubWord
                  if (state_q == S_SUB && i_q == 2'd3) begin
                     t_q[0] <= s_q[0] ^ rcon_q;
                     t_q[1] <= s_q[1];
                     t_q[2] <= s_q[2];
                     t_q[3] <= sbox_q0[7:0];
                     rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                  end
                  if (state_q == S_XOR && i_q == 2'd3) col_q <= col_q + 6'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      ap_done       = (state_q == S_DONE);
      ap_ready      = (state_q == S_DONE);
      ap_idle       = (state_q == S_IDLE) && !ap_start;
      key_ce0       = 1'b0;
      key_address0  = 5'd0;
      sbox_ce0      = 1'b0;
      sbox_address0 = 8'd0;
      word_ce0      = 1'b0;
      word_we0      = 1'b0;
      word_address0 = 9'd0;
      word_d0       = 32'd0;
      word_ce1      = 1'b0;
      word_address1 = 9'd0;
      case (state_q)
         S_KRD: begin
            key_ce0      = 1'b1;
            key_address0 = {1'b0, col_q[1:0], i_q};
         end
         S_KWR: begin
            word_ce0      = 1'b1;
            word_we0      = 1'b1;
            word_address0 = row_base + col_ext;
            word_d0       = {24'd0, key_q0[7:0]};
         end
         S_PREV: begin
            if (!ph_q) begin
               word_ce1      = 1'b1;
               word_address1 = row_base + col_ext - 9'd1;
            end
         end
         S_SUB: begin
            if (!ph_q) begin
               sbox_ce0      = 1'b1;
               sbox_address0 = t_q[i_nxt];
            end
         end
         S_XOR: begin
            if (!ph_q) begin
               word_ce1      = 1'b1;
               word_address1 = row_base + col_ext - 9'd4;
            end else begin
               word_ce0      = 1'b1;
               word_we0      = 1'b1;
               word_address0 = row_base + col_ext;
               word_d0       = {24'd0, word_q1[7:0] ^ t_q[i_q]};
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_aes_key_expansion.sv
// Self-checking bench for aes_key_expansion: BRAM/ROM models, a reference key schedule
// feeding a write scoreboard, and latency, reset-abort and back-to-back checks.
module tb_aes_key_expansion;

   localparam int ROW_STRIDE = 120;
   localparam int NUM_COLS   = 44;

   logic        ap_clk = 1'b0;
   logic        ap_rst = 1'b1;
   logic        ap_start = 1'b0;
   logic        ap_done, ap_idle, ap_ready;
   logic [4:0]  key_address0;
   logic        key_ce0;
   logic [31:0] key_q0 = 32'd0;
   logic [7:0]  sbox_address0;
   logic        sbox_ce0;
   logic [31:0] sbox_q0 = 32'd0;
   logic [8:0]  word_address0;
   logic        word_ce0, word_we0;
   logic [31:0] word_d0;
   logic [8:0]  word_address1;
   logic        word_ce1;
   logic [31:0] word_q1 = 32'd0;

   aes_key_expansion #(.ROW_STRIDE(ROW_STRIDE), .NUM_COLS(NUM_COLS)) dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
      .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
      .key_address0(key_address0), .key_ce0(key_ce0), .key_q0(key_q0),
      .sbox_address0(sbox_address0), .sbox_ce0(sbox_ce0), .sbox_q0(sbox_q0),
      .word_address0(word_address0), .word_ce0(word_ce0), .word_we0(word_we0),
      .word_d0(word_d0), .word_address1(word_address1), .word_ce1(word_ce1),
      .word_q1(word_q1)
   );

   always #5 ap_clk = ~ap_clk;

   logic [2047:0] sbox_flat = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [7:0] sb(input logic [7:0] x);
      return sbox_flat[2047 - 8 * int'(x) -: 8];
   endfunction

   typedef struct packed {
      logic [8:0] addr;
      logic [7:0] data;
   } exp_t;

   exp_t       sb_q [$];
   logic [7:0] key_mem [16];
   logic [7:0] word_mem [512];
   logic       mem_clr = 1'b0;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   int         wr_cnt = 0;
   int         done_cnt = 0;
   int         last_wr_cyc = 0;
   int         rw_conflicts = 0;
   int         hs_errs = 0;

   always @(posedge ap_clk) cyc <= cyc + 1;

   // Memory models; upper bits of every read are random junk the DUT must ignore.
   always @(posedge ap_clk) begin
      if (mem_clr) for (int k = 0; k < 512; k++) word_mem[k] <= 8'd0;
      if (key_ce0) key_q0 <= ($urandom() & 32'hffffff00) | {24'd0, key_mem[key_address0[3:0]]};
      if (sbox_ce0) sbox_q0 <= ($urandom() & 32'hffffff00) | {24'd0, sb(sbox_address0)};
      if (word_ce1) word_q1 <= ($urandom() & 32'hffffff00) | {24'd0, word_mem[word_address1]};
      if (word_ce0 && word_we0) word_mem[word_address0] <= word_d0[7:0];
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge ap_clk) begin
      if (word_ce0 && word_we0) begin
         exp_t e;
         wr_cnt++;
         last_wr_cyc = cyc;
         if (word_ce1 && word_address1 == word_address0) rw_conflicts++;
         if (sb_q.size() == 0) begin
            check_eq("sb_unexpected_wr", {23'd0, word_address0}, 32'hffffffff);
         end else begin
            e = sb_q.pop_front();
            check_eq("wr_addr", {23'd0, word_address0}, {23'd0, e.addr});
            check_eq("wr_data", word_d0, {24'd0, e.data});
         end
      end
      if (ap_done) done_cnt++;
      if (ap_ready != ap_done) hs_errs++;
   end

   task automatic set_key(input logic [127:0] k);
      for (int b = 0; b < 16; b++) key_mem[b] = k[127 - 8 * b -: 8];
   endtask

   task automatic push_expected();
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  rc;
      exp_t        e;
      rc = 8'h01;
      for (int c = 0; c < NUM_COLS; c++) begin
         if (c < 4) begin
            w[c] = {key_mem[4*c], key_mem[4*c+1], key_mem[4*c+2], key_mem[4*c+3]};
         end else begin
            tmp = w[c-1];
            if (c % 4 == 0) begin
               tmp = {sb(tmp[23:16]) ^ rc, sb(tmp[15:8]), sb(tmp[7:0]), sb(tmp[31:24])};
               rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[c] = w[c-4] ^ tmp;
         end
         for (int r = 0; r < 4; r++) begin
            e.addr = 9'(r * ROW_STRIDE + c);
            e.data = w[c][31 - 8 * r -: 8];
            sb_q.push_back(e);
         end
      end
   endtask

   task automatic clear_word_mem();
      mem_clr = 1'b1;
      @(negedge ap_clk);
      mem_clr = 1'b0;
   endtask

   // Waits for ap_done from the current negedge; returns the cycle seen, or -1 on timeout.
   task automatic wait_done(output int at);
      at = -1;
      for (int n = 0; n < 2000; n++) begin
         if (ap_done) begin
            at = cyc;
            break;
         end
         @(negedge ap_clk);
      end
      if (at < 0) check_eq("done_timeout", 32'(n_dummy()), 32'd1);
   endtask

   function automatic int n_dummy();
      return int'(ap_done);
   endfunction

   task automatic run_once(input string tag);
      int t0, at;
      clear_word_mem();
      push_expected();
      wr_cnt   = 0;
      done_cnt = 0;
      ap_start = 1'b1;
      t0 = cyc;
      @(negedge ap_clk);
      ap_start = 1'b0;
      wait_done(at);
      check_eq({tag, "_latency"}, 32'(at - t0), 32'd753);
      @(negedge ap_clk);
      check_eq({tag, "_idle_after"}, {31'd0, ap_idle}, 32'd1);
      check_eq({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd176);
      check_eq({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check_eq({tag, "_sb_left"}, 32'(sb_q.size()), 32'd0);
   endtask

   task automatic check_fips(input string tag);
      check_eq({tag, "_w0"}, {24'd0, word_mem[0]}, 32'h2b);
      check_eq({tag, "_w4"}, {24'd0, word_mem[4]}, 32'ha0);
      check_eq({tag, "_w124"}, {24'd0, word_mem[124]}, 32'hfa);
      check_eq({tag, "_w244"}, {24'd0, word_mem[244]}, 32'hfe);
      check_eq({tag, "_w364"}, {24'd0, word_mem[364]}, 32'h17);
      check_eq({tag, "_w43"}, {24'd0, word_mem[43]}, 32'hb6);
      check_eq({tag, "_w163"}, {24'd0, word_mem[163]}, 32'h63);
      check_eq({tag, "_w283"}, {24'd0, word_mem[283]}, 32'h0c);
      check_eq({tag, "_w403"}, {24'd0, word_mem[403]}, 32'ha6);
   endtask

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   initial begin
      int t0, at;
      set_key(FIPS_KEY);
      repeat (3) @(negedge ap_clk);
      ap_rst = 1'b0;

      repeat (5) begin
         @(negedge ap_clk);
         check_eq("idle_rst", {31'd0, ap_idle}, 32'd1);
         check_eq("outs_rst", {26'd0, key_ce0, sbox_ce0, word_ce0, word_ce1, ap_done, ap_ready},
                  32'd0);
      end

      run_once("fips");
      check_fips("fips");

      set_key(128'd0);
      run_once("zero");
      for (int c = 4; c < 8; c++) check_eq("zero_row0", {24'd0, word_mem[c]}, 32'h62);
      check_eq("zero_w364", {24'd0, word_mem[364]}, 32'h63);
      check_eq("zero_w40", {24'd0, word_mem[40]}, 32'hb4);

      // Abort a run with reset mid-expansion.
      set_key(FIPS_KEY);
      clear_word_mem();
      push_expected();
      done_cnt = 0;
      ap_start = 1'b1;
      t0 = cyc;
      @(negedge ap_clk);
      ap_start = 1'b0;
      while (cyc < t0 + 200) @(negedge ap_clk);
      ap_rst = 1'b1;
      @(negedge ap_clk);
      ap_rst = 1'b0;
      sb_q.delete();
      repeat (30) @(negedge ap_clk);
      check_eq("abort_last_wr", {31'd0, last_wr_cyc <= t0 + 200}, 32'd1);
      check_eq("abort_no_done", 32'(done_cnt), 32'd0);
      check_eq("abort_idle", {31'd0, ap_idle}, 32'd1);
      check_eq("abort_ce", {28'd0, key_ce0, sbox_ce0, word_ce0, word_ce1}, 32'd0);
      run_once("restart");
      check_fips("restart");

      // ap_start held high: second run begins the cycle after DONE.
      clear_word_mem();
      push_expected();
      push_expected();
      wr_cnt   = 0;
      done_cnt = 0;
      ap_start = 1'b1;
      t0 = cyc;
      @(negedge ap_clk);
      wait_done(at);
      check_eq("b2b_lat1", 32'(at - t0), 32'd753);
      @(negedge ap_clk);
      check_eq("b2b_idle_low", {31'd0, ap_idle}, 32'd0);
      clear_word_mem();
      wait_done(at);
      check_eq("b2b_lat2", 32'(at - t0), 32'd1507);
      ap_start = 1'b0;
      @(negedge ap_clk);
      check_eq("b2b_wr_cnt", 32'(wr_cnt), 32'd352);
      check_eq("b2b_done_cnt", 32'(done_cnt), 32'd2);
      check_eq("b2b_sb_left", 32'(sb_q.size()), 32'd0);
      check_eq("b2b_w4", {24'd0, word_mem[4]}, 32'ha0);
      check_eq("b2b_w403", {24'd0, word_mem[403]}, 32'ha6);

      check_eq("rw_conflicts", 32'(rw_conflicts), 32'd0);
      check_eq("ready_eq_done", 32'(hs_errs), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout cyc=%0d limit=200000", cyc);
      $fatal(1);
   end

endmodule
